mio_int_ctrl: RTL and testbench

//  Interrupt controller between the counter/timer block and the CPU INT input, programmed over the MIO bus.
//  - Synchronises N_SRC raw request lines (counter0/1/2 outputs, which toggle on divided clocks) into the CPU clock domain.
//  - Latches each request as pending and applies per-source masks and a global enable.
//  - Drives a registered INT level and a priority-encoded cause register that the ISR reads and clears.

---
 rtl/mio_int_if.sv | 31 +++
 rtl/mio_int_ctrl.sv | 130 +++++++++++++
 tb/tb_mio_int_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mio_int_if.sv
// MIO bus slice for the interrupt controller.
// Carries the decoded register write/read path and the ISR-entry acknowledge.
//   int_we     write strobe, already decoded for this block's address window
//   int_addr   register select (bus address [3:2])
//   int_wdata  write data
//   int_rdata  read data for the selected register, combinational from int_addr
//   int_ack    1-cycle pulse when the CPU enters the ISR
// master = CPU/bus side, slave = interrupt controller.
interface mio_int_if;
  logic        int_we;
  logic [1:0]  int_addr;
  logic [31:0] int_wdata;
  logic [31:0] int_rdata;
  logic        int_ack;

  modport master (
    output int_we,
    output int_addr,
    output int_wdata,
    output int_ack,
    input  int_rdata
  );

  modport slave (
    input  int_we,
    input  int_addr,
    input  int_wdata,
    input  int_ack,
    output int_rdata
  );
endinterface

// File: rtl/mio_int_ctrl.sv
// Interrupt controller between the counter/timer block and the CPU INT input.
// Raw request lines are synchronised into clk, latched as pending (rising-edge
// or level mode per source), gated by per-source masks and a global enable,
// and presented as a registered INT level plus a priority-encoded CAUSE.
// Ports:
//   clk      CPU-side clock
//   rst      synchronous reset, active-high
//   irq_raw  N_SRC raw requests, asynchronous to clk (bit 0 = highest priority)
//   bus      MIO register slice (slave modport): PEND / MASK / CAUSE / CTRL
//   INT      interrupt request level to the CPU
// Register map (bus.int_addr):
//   0 PEND  R/W1C  1 MASK  R/W  2 CAUSE  R ([31]=valid, [2:0]=idx)
//   3 CTRL  R/W    [0]=GIE, [8+i]=LVL_i
module mio_int_ctrl #(
  parameter int N_SRC       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_raw,
  mio_int_if.slave         bus,
  output logic             INT
);

  logic [N_SRC-1:0] sync_p [SYNC_STAGES];
  logic [N_SRC-1:0] s_lvl;
  logic [N_SRC-1:0] hist_p;
  logic [N_SRC-1:0] rise;

  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] lvl;
  logic             gie;

  logic [N_SRC-1:0] enabled;
  logic             cause_valid;
  logic [2:0]       cause_idx;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] pend_nxt;

  logic wr_pend;
  logic wr_mask;
  logic wr_ctrl;
  logic wdata_unused;

  assign wr_pend = bus.int_we && (bus.int_addr == 2'd0);
  assign wr_mask = bus.int_we && (bus.int_addr == 2'd1);
  assign wr_ctrl = bus.int_we && (bus.int_addr == 2'd3);

  // Only a few write-data bits are architected; the rest are don't-care.
  assign wdata_unused = ^bus.int_wdata;

  // Stage p0..: synchroniser chain, then one-cycle history for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= '0;
      hist_p <= '0;
    end else begin
      sync_p[0] <= irq_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
      hist_p <= s_lvl;
    end
  end

  assign s_lvl = sync_p[SYNC_STAGES-1];
  assign rise  = s_lvl & ~hist_p;

  // Lowest-numbered enabled pending source wins; independent of GIE so the
  // ISR can still poll with interrupts globally disabled.
  assign enabled = pend & mask;

  always_comb begin
    cause_valid = 1'b0;
    cause_idx   = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (enabled[i]) begin
        cause_valid = 1'b1;
        cause_idx   = 3'(i);
      end
    end
  end

  // W1C and ack clears OR together; a same-cycle rise overrides any clear.
  // Level-mode sources simply follow the synchronised line.
  always_comb begin
    clr      = '0;
    pend_nxt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = (wr_pend & bus.int_wdata[i]) |
               (bus.int_ack & cause_valid & (cause_idx == 3'(i)));
      pend_nxt[i] = lvl[i] ? s_lvl[i] : (rise[i] | (pend[i] & ~clr[i]));
    end
  end

  // Stage: pending/config registers and the registered INT level
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      mask <= '0;
      lvl  <= '0;
      gie  <= 1'b0;
      INT  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (wr_mask) mask <= bus.int_wdata[N_SRC-1:0];
      if (wr_ctrl) begin
        gie <= bus.int_wdata[0];
        lvl <= bus.int_wdata[8 +: N_SRC];
      end
      INT <= gie & (|enabled);
    end
  end

  always_comb begin
    bus.int_rdata = '0;
    case (bus.int_addr)
      2'd0: bus.int_rdata[N_SRC-1:0] = pend;
      2'd1: bus.int_rdata[N_SRC-1:0] = mask;
      2'd2: begin
        bus.int_rdata[31]  = cause_valid;
        bus.int_rdata[2:0] = cause_idx;
      end
      default: begin
        bus.int_rdata[0]          = gie;
        bus.int_rdata[8 +: N_SRC] = lvl;
      end
    endcase
  end

endmodule

// File: tb/tb_mio_int_ctrl.sv
module tb_mio_int_ctrl;
  localparam int N_SRC = 3;
  localparam int SYNC  = 2;

  logic             clk;
  logic             rst;
  logic [N_SRC-1:0] irq_raw;
  logic             int_o;

  mio_int_if bus ();

  mio_int_ctrl #(.N_SRC(N_SRC), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_raw (irq_raw),
    .bus     (bus),
    .INT     (int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [2:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_int;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string nm);
    bus.int_addr = a;
    #1;
    chk(nm, bus.int_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.int_we    = 1'b1;
    bus.int_addr  = a;
    bus.int_wdata = d;
    step();
    bus.int_we    = 1'b0;
    bus.int_wdata = '0;
  endtask

  initial begin
    // Each row is one clock cycle: inputs driven just after the edge,
    // outputs compared at the falling edge (state left by earlier rows).
    //          r  irq     we  addr  wdata          ack chk exp_rd         int
    tbl[0]  = '{1, 3'b000, 0, 2'd0, 32'h0,         0,  0, 32'h0,         0};
    tbl[1]  = '{1, 3'b000, 0, 2'd0, 32'h0,         0,  0, 32'h0,         0};
    tbl[2]  = '{0, 3'b000, 0, 2'd0, 32'h0,         0,  1, 32'h0,         0};
    tbl[3]  = '{0, 3'b000, 0, 2'd1, 32'h0,         0,  1, 32'h0,         0};
    tbl[4]  = '{0, 3'b000, 0, 2'd2, 32'h0,         0,  1, 32'h0,         0};
    tbl[5]  = '{0, 3'b000, 0, 2'd3, 32'h0,         0,  1, 32'h0,         0};
    tbl[6]  = '{0, 3'b000, 1, 2'd1, 32'hFFFF_FFFF, 0,  1, 32'h0,         0};
    tbl[7]  = '{0, 3'b000, 0, 2'd1, 32'h0,         0,  1, 32'h7,         0};
    tbl[8]  = '{0, 3'b000, 1, 2'd3, 32'h1,         0,  1, 32'h0,         0};
    tbl[9]  = '{0, 3'b000, 0, 2'd3, 32'h0,         0,  1, 32'h1,         0};
    tbl[10] = '{0, 3'b100, 0, 2'd2, 32'h0,         0,  1, 32'h0,         0};
    tbl[11] = '{0, 3'b101, 0, 2'd0, 32'h0,         0,  1, 32'h0,         0};
    tbl[12] = '{0, 3'b101, 0, 2'd0, 32'h0,         0,  1, 32'h0,         0};
    tbl[13] = '{0, 3'b101, 0, 2'd0, 32'h0,         0,  1, 32'h4,         0};
    tbl[14] = '{0, 3'b101, 0, 2'd2, 32'h0,         0,  1, 32'h8000_0000, 1};
    tbl[15] = '{0, 3'b101, 0, 2'd2, 32'h0,         1,  1, 32'h8000_0000, 1};
    tbl[16] = '{0, 3'b101, 0, 2'd2, 32'h0,         0,  1, 32'h8000_0002, 1};
    tbl[17] = '{0, 3'b101, 0, 2'd0, 32'h0,         0,  1, 32'h4,         1};
    tbl[18] = '{0, 3'b101, 0, 2'd0, 32'h0,         1,  1, 32'h4,         1};
    tbl[19] = '{0, 3'b101, 0, 2'd0, 32'h0,         0,  1, 32'h0,         1};
    tbl[20] = '{0, 3'b000, 0, 2'd2, 32'h0,         1,  1, 32'h0,         0};
    tbl[21] = '{0, 3'b000, 0, 2'd0, 32'h0,         0,  1, 32'h0,         0};

    rst           = 1'b1;
    irq_raw       = '0;
    bus.int_we    = 1'b0;
    bus.int_addr  = 2'd0;
    bus.int_wdata = '0;
    bus.int_ack   = 1'b0;
    #1;

    // Reset, register access, priority and ack sequencing
    for (int v = 0; v < NV; v++) begin
      rst           = tbl[v].r;
      irq_raw       = tbl[v].irq;
      bus.int_we    = tbl[v].we;
      bus.int_addr  = tbl[v].addr;
      bus.int_wdata = tbl[v].wdata;
      bus.int_ack   = tbl[v].ack;
      #4;
      if (tbl[v].chk) begin
        chk($sformatf("vec%0d_rdata", v), bus.int_rdata, tbl[v].exp_rd);
        chk($sformatf("vec%0d_int", v), {31'b0, int_o}, {31'b0, tbl[v].exp_int});
      end
      step();
    end
    bus.int_we  = 1'b0;
    bus.int_ack = 1'b0;
    step();
    step();

    // Edge latency: INT rises exactly SYNC+2 cycles after the raw edge
    irq_raw = 3'b010;
    for (int k = 1; k <= SYNC + 2; k++) begin
      step();
      if (k == 3) irq_raw = 3'b000;
      chk($sformatf("lat_int_k%0d", k), {31'b0, int_o}, {31'b0, (k == SYNC + 2)});
    end
    rd_chk(2'd0, 32'h2, "lat_pend");
    rd_chk(2'd2, 32'h8000_0001, "lat_cause");
    wr(2'd0, 32'h2);
    rd_chk(2'd0, 32'h0, "w1c_pend");
    step();
    chk("w1c_int", {31'b0, int_o}, 32'h0);

    // Collision: W1C of bit 0 in the same cycle rise_0 fires
    irq_raw = 3'b001;
    repeat (SYNC + 2) step();
    rd_chk(2'd0, 32'h1, "col_pre_pend");
    chk("col_pre_int", {31'b0, int_o}, 32'h1);
    irq_raw = 3'b000;
    repeat (SYNC + 1) step();
    irq_raw = 3'b001;
    repeat (SYNC) step();
    wr(2'd0, 32'h1);
    rd_chk(2'd0, 32'h1, "col_pend");
    chk("col_int", {31'b0, int_o}, 32'h1);
    step();
    chk("col_int_next", {31'b0, int_o}, 32'h1);
    wr(2'd0, 32'h1);
    rd_chk(2'd0, 32'h0, "col_clear_pend");

    // Mask / GIE gating
    irq_raw = 3'b000;
    repeat (SYNC + 1) step();
    wr(2'd1, 32'h0);
    irq_raw = 3'b001;
    repeat (SYNC + 2) step();
    rd_chk(2'd0, 32'h1, "mask_pend");
    rd_chk(2'd2, 32'h0, "mask_cause");
    chk("mask_int", {31'b0, int_o}, 32'h0);
    wr(2'd1, 32'h1);
    chk("unmask_int_same", {31'b0, int_o}, 32'h0);
    step();
    chk("unmask_int_next", {31'b0, int_o}, 32'h1);
    wr(2'd3, 32'h0);
    chk("gie_off_int_same", {31'b0, int_o}, 32'h1);
    step();
    chk("gie_off_int_next", {31'b0, int_o}, 32'h0);
    rd_chk(2'd2, 32'h8000_0000, "gie_off_cause");

    // Level mode, then reset mid-operation
    wr(2'd3, 32'h101);
    rd_chk(2'd3, 32'h101, "lvl_ctrl");
    wr(2'd0, 32'h1);
    rd_chk(2'd0, 32'h1, "lvl_w1c_pend");
    chk("lvl_int", {31'b0, int_o}, 32'h1);
    irq_raw = 3'b000;
    repeat (SYNC) step();
    rd_chk(2'd0, 32'h1, "lvl_fall_pend_early");
    step();
    rd_chk(2'd0, 32'h0, "lvl_fall_pend");
    irq_raw = 3'b001;
    repeat (SYNC + 2) step();
    rd_chk(2'd0, 32'h1, "lvl_rise_pend");
    chk("lvl_rise_int", {31'b0, int_o}, 32'h1);
    rst     = 1'b1;
    irq_raw = 3'b000;
    step();
    rst = 1'b0;
    chk("rst_int", {31'b0, int_o}, 32'h0);
    rd_chk(2'd0, 32'h0, "rst_pend");
    rd_chk(2'd1, 32'h0, "rst_mask");
    rd_chk(2'd2, 32'h0, "rst_cause");
    rd_chk(2'd3, 32'h0, "rst_ctrl");
    repeat (SYNC + 2) step();
    rd_chk(2'd0, 32'h0, "post_rst_pend");
    chk("post_rst_int", {31'b0, int_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
